// File: rtl/uart_tx_buffer_if.sv
// uart_tx_buffer_if: byte-write, status and serial-line signals of uart_tx_buffer.
interface uart_tx_buffer_if #(
   parameter int FIFO_DEPTH = 16
);
   logic [7:0]                    key_dat;
   logic                          key_wen;
   logic                          ovf_clr;
   logic                          tx;
   logic                          tx_busy;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic                          overflow;
   modport master (
      output key_dat, key_wen, ovf_clr,
      input  tx, tx_busy, fifo_full, fifo_empty, fifo_count, overflow
   );
   modport slave (
      input  key_dat, key_wen, ovf_clr,
      output tx, tx_busy, fifo_full, fifo_empty, fifo_count, overflow
   );
endinterface

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO feeding an 8N1 UART transmitter.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_buffer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input logic             clk_100,
   input logic             rst_n,
   uart_tx_buffer_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] RELOAD = BW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t        r_state;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_count;
   logic          r_full;
   logic          r_empty;
   logic          r_ovf;
   logic          r_tx;
   logic          r_busy;
   logic [BW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_sh;
   logic          w_push;
   logic          w_pop;
   logic          w_idle_nxt;
   logic [CW-1:0] w_count_nxt;
   assign w_push      = bus.key_wen & ~r_full;
   assign w_pop       = (r_state == IDLE) & ~r_empty;
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
   // FSM lands in IDLE next cycle: stays idle with nothing queued, or the stop bit ends
   assign w_idle_nxt  = (r_state == IDLE) ? r_empty : (r_state == STOP) && (r_cnt == '0);
   assign bus.tx         = r_tx;
   assign bus.tx_busy    = r_busy;
   assign bus.fifo_full  = r_full;
   assign bus.fifo_empty = r_empty;
   assign bus.fifo_count = r_count;
   assign bus.overflow   = r_ovf;
   always_ff @(posedge clk_100)
      if (w_push) r_mem[r_wr] <= bus.key_dat;
   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_ovf   <= 1'b0;
      end else begin
         r_wr    <= r_wr + AW'(w_push);
         r_rd    <= r_rd + AW'(w_pop);
         r_count <= w_count_nxt;
         r_full  <= w_count_nxt == CW'(FIFO_DEPTH);
         r_empty <= w_count_nxt == '0;
         r_ovf   <= (bus.key_wen & r_full) | (r_ovf & ~bus.ovf_clr);
      end
   end
   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_sh    <= '0;
      end else begin
         r_busy <= ~w_idle_nxt | (w_count_nxt != '0);
         case (r_state)
            IDLE:
               if (!r_empty) begin
                  r_sh    <= r_mem[r_rd];
                  r_bit   <= '0;
                  r_cnt   <= RELOAD;
                  r_tx    <= 1'b0;
                  r_state <= START;
               end
            START:
               if (r_cnt == '0) begin
                  r_cnt   <= RELOAD;
                  r_tx    <= r_sh[0];
                  r_state <= DATA;
               end else r_cnt <= r_cnt - BW'(1);
            DATA:
               if (r_cnt == '0) begin
                  r_cnt <= RELOAD;
                  r_bit <= r_bit + 3'd1;
                  if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_tx    <= ^r_sh;
                     r_state <= PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= STOP;
`endif
                  end else r_tx <= r_sh[r_bit + 3'd1];
               end else r_cnt <= r_cnt - BW'(1);
`ifdef UART_TX_PARITY_EN
            PARITY:
               if (r_cnt == '0) begin
                  r_cnt   <= RELOAD;
                  r_tx    <= 1'b1;
                  r_state <= STOP;
               end else r_cnt <= r_cnt - BW'(1);
`endif
            STOP:
               if (r_cnt == '0) r_state <= IDLE;
               else r_cnt <= r_cnt - BW'(1);
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
Transmit-direction counterpart of the terminal's UART receive path. It accepts byte writes from the terminal/keyboard side as a single-cycle write-enable pulse with data, and buffers them in a small FIFO. It then serializes each byte as an 8N1 UART frame on the tx pin. The block sits between the character/key source logic on clk_100 and the board's UART TX pin.

Parameters:
CLKS_PER_BIT, 868, clk_100 cycles per UART bit (115200 baud at 100 MHz); minimum 2.
FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 2.

Ports:
clk_100  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
key_dat  input  8  byte to transmit; sampled when key_wen=1.
key_wen  input  1  write strobe; one push per cycle high.
ovf_clr  input  1  clears the sticky overflow flag.
tx  output  1  UART serial line; idles high.
tx_busy  output  1  high while a frame is in progress or the FIFO is non-empty.
fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
fifo_empty  output  1  FIFO holds 0 entries.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
overflow  output  1  sticky flag: a write was dropped.

Behaviour:
- Reset (rst_n low, async, takes effect immediately): tx=1, tx_busy=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0, FSM=IDLE. FIFO contents are discarded. A frame in flight is aborted; no partial frame resumes after release.
- Push: key_wen=1 and fifo_full=0 (registered value, before any same-cycle pop) -> write key_dat at wr_ptr. Pointers wrap modulo FIFO_DEPTH.
- Push while full: the byte is dropped and overflow<=1, even if a pop occurs in the same cycle.
- overflow clears on ovf_clr=1. If a set and a clear coincide, the set wins.
- Simultaneous push and pop: count unchanged; both pointers advance.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
  - IDLE: tx=1. If fifo_empty=0: pop the head into the shift register, clear the bit counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles. After bit 7, go to STOP (or PARITY).
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: key_wen at cycle N into an empty FIFO in IDLE -> fifo_empty=0 at N+1, pop at N+1, tx falls at N+2.
- Frame length: 10*CLKS_PER_BIT cycles. Back-to-back frames are separated by exactly 1 idle cycle (tx=1).
- The baud counter is a down-counter reloaded to CLKS_PER_BIT-1 on every state/bit change. It has no drift across frames.
- tx is driven from a register (glitch-free).
- tx_busy = (state != IDLE) | ~fifo_empty, registered with the rest of the state.
- Transmission order equals write order.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted after DATA. tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles. Frame length is 11*CLKS_PER_BIT.
- Undefined: no PARITY state, 8N1 frames only, and no parity logic is synthesized.

Test Plan:
(All with CLKS_PER_BIT=4, FIFO_DEPTH=4.)
1. Single byte: after reset, key_dat=0x55 with key_wen=1 at cycle N.
   -> tx falls at N+2. Bit sequence 0(start),1,0,1,0,1,0,1,0,1(stop), each bit 4 cycles, 40 cycles total. tx_busy falls when the stop bit ends.
2. Back-to-back: write 0x41, 0x42, 0x43 on consecutive cycles.
   -> Three frames in order 0x41, 0x42, 0x43, each separated by exactly 1 high cycle. Peak fifo_count=2.
3. Overflow: write 0xA0..0xA5 on 6 consecutive cycles.
   -> 0xA0 popped immediately and 0xA1..0xA4 buffered (fifo_full=1). 0xA5 dropped and overflow=1. Exactly 5 frames are sent.
   -> Pulse ovf_clr -> overflow=0 the next cycle.
4. Set/clear collision: with the FIFO full, drive key_wen=1 and ovf_clr=1 in the same cycle.
   -> overflow=1 the next cycle.
5. Reset mid-frame: drop rst_n during data bit 3 of 0xFF, with 2 bytes still queued.
   -> tx=1 asynchronously, fifo_count=0, tx_busy=0. After release, tx stays high with no frames.
6. Parity (UART_TX_PARITY_EN defined): send 0x07.
   -> Parity bit=1, 44-cycle frame. Send 0x03 -> parity bit=0.
